// File: rtl/guess_round_ctrl.sv
// Round controller for the number-guessing game: timed rounds, mode-dependent match
// rule, saturating correct/incorrect tallies and a verdict/sound strobe.
module guess_round_ctrl #(
    parameter int GUESS_W     = 4,
    parameter int NUM_ROUNDS  = 10,
    parameter int ROUND_TICKS = 500_000_000,
    parameter int SOUND_TICKS = 50_000_000,
    parameter int CNT_W       = $clog2(NUM_ROUNDS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ready,
    input  logic [1:0]         game_mode,
    input  logic               submit,
    input  logic [GUESS_W-1:0] user_guess,
    input  logic [GUESS_W-1:0] rand_value,
    output logic               new_value,
    output logic [CNT_W-1:0]   round,
    output logic [CNT_W-1:0]   user_correct,
    output logic [CNT_W-1:0]   user_incorrect,
    output logic               play_sound,
    output logic               val,
    output logic               busy,
    output logic               game_done,
    output logic [2:0]         o_dbg_state
);
    // new_value is a one-cycle request with no acknowledge: the RNG presents a fresh
    // rand_value and holds it stable until the next request pulse.
    localparam int TMR_W = $clog2(ROUND_TICKS);
    localparam int SND_W = $clog2(SOUND_TICKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ROUND_TICKS - 1);
    localparam logic [SND_W-1:0] SND_LAST   = SND_W'(SOUND_TICKS - 1);
    localparam logic [CNT_W-1:0] ROUNDS_END = CNT_W'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_SOUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_ready_q;
    logic [TMR_W-1:0]   r_timer;
    logic [SND_W-1:0]   r_snd_cnt;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_round;
    logic [CNT_W-1:0]   r_correct;
    logic [CNT_W-1:0]   r_incorrect;
    logic               r_val;
    logic               r_new_value;
    logic               r_play_sound;
    logic               r_busy;
    logic               r_game_done;
    logic               w_new_value_nxt;
    logic               w_play_sound_nxt;
    logic               w_busy_nxt;
    logic               w_game_done_nxt;
    logic               w_eval;
    logic               w_match;
    logic               w_start;
    logic               w_snd_last;

    assign w_eval     = (r_state == S_PLAY) && (submit || (r_timer == TMR_LAST));
    assign w_snd_last = (r_snd_cnt == SND_LAST);
    assign w_start    = (r_state == S_IDLE) && (w_next == S_ARM);

    always_comb begin
        w_match = 1'b0;
        case (r_mode)
            2'b10:   w_match = (user_guess == rand_value);
            2'b11:   w_match = (user_guess[2:0] == rand_value[2:0]);
            default: w_match = (user_guess == rand_value) && (user_guess <= GUESS_W'(9));
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Start is taken from the registered ready, so ARM begins one edge after ready is seen.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_ready_q) w_next = S_ARM;
            S_ARM:   w_next = S_PLAY;
            S_PLAY:  if (!ready) w_next = S_IDLE;
                     else if (w_eval) w_next = S_SOUND;
            S_SOUND: if (w_snd_last) w_next = (r_round == ROUNDS_END) ? S_DONE : S_ARM;
            S_DONE:  if (!ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_new_value_nxt  = (w_next == S_ARM);
        w_play_sound_nxt = (w_next == S_SOUND);
        w_busy_nxt       = (w_next == S_ARM) || (w_next == S_PLAY) || (w_next == S_SOUND);
        w_game_done_nxt  = (w_next == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_new_value  <= 1'b0;
            r_play_sound <= 1'b0;
            r_busy       <= 1'b0;
            r_game_done  <= 1'b0;
        end else begin
            r_new_value  <= w_new_value_nxt;
            r_play_sound <= w_play_sound_nxt;
            r_busy       <= w_busy_nxt;
            r_game_done  <= w_game_done_nxt;
        end
    end

    // A verdict commits even when ready drops in the same cycle; only the transition is aborted.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ready_q   <= 1'b0;
            r_timer     <= '0;
            r_snd_cnt   <= '0;
            r_mode      <= 2'b00;
            r_round     <= '0;
            r_correct   <= '0;
            r_incorrect <= '0;
            r_val       <= 1'b0;
        end else begin
            r_ready_q <= ready;
            if (r_state == S_ARM)       r_timer <= '0;
            else if (r_state == S_PLAY) r_timer <= r_timer + 1'b1;
            if (r_state == S_SOUND) r_snd_cnt <= r_snd_cnt + 1'b1;
            else                    r_snd_cnt <= '0;
            if (w_start) begin
                r_mode      <= game_mode;
                r_round     <= '0;
                r_correct   <= '0;
                r_incorrect <= '0;
            end else if (w_eval) begin
                if (r_round != '1) r_round <= r_round + 1'b1;
                if (w_match) begin
                    if (r_correct != '1) r_correct <= r_correct + 1'b1;
                    r_val <= 1'b0;
                end else begin
                    if (r_incorrect != '1) r_incorrect <= r_incorrect + 1'b1;
                    r_val <= 1'b1;
                end
            end
        end
    end

    assign new_value      = r_new_value;
    assign play_sound     = r_play_sound;
    assign busy           = r_busy;
    assign game_done      = r_game_done;
    assign round          = r_round;
    assign user_correct   = r_correct;
    assign user_incorrect = r_incorrect;
    assign val            = r_val;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// Directed bench for guess_round_ctrl with a 3-round, 8-tick round, 2-tick sound build.
module tb_guess_round_ctrl;
    localparam int GW = 4;
    localparam int NR = 3;
    localparam int RT = 8;
    localparam int ST = 2;
    localparam int CW = $clog2(NR + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ready = 1'b0;
    logic [1:0]    game_mode = 2'b00;
    logic          submit = 1'b0;
    logic [GW-1:0] user_guess = '0;
    logic [GW-1:0] rand_value = '0;
    logic          new_value;
    logic [CW-1:0] round;
    logic [CW-1:0] user_correct;
    logic [CW-1:0] user_incorrect;
    logic          play_sound;
    logic          val;
    logic          busy;
    logic          game_done;
    logic [2:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    guess_round_ctrl #(
        .GUESS_W(GW), .NUM_ROUNDS(NR), .ROUND_TICKS(RT), .SOUND_TICKS(ST)
    ) dut (
        .clock(clock), .reset(reset), .ready(ready), .game_mode(game_mode),
        .submit(submit), .user_guess(user_guess), .rand_value(rand_value),
        .new_value(new_value), .round(round), .user_correct(user_correct),
        .user_incorrect(user_incorrect), .play_sound(play_sound), .val(val),
        .busy(busy), .game_done(game_done), .o_dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_new_value(input string tag);
        int n = 0;
        while (!new_value && n < 40) begin
            tick();
            n++;
        end
        check_eq({tag, "_new_value_seen"}, 32'(new_value), 32'd1);
    endtask

    // Entry: just after the edge that raised new_value. Exit: just after SOUND ends.
    task automatic play_round(input string tag, input int submit_at, input bit sound_submit,
                              input logic exp_val, input int exp_round, input int exp_c,
                              input int exp_i, input bit last);
        int ev;
        wait_new_value(tag);
        ev = (submit_at > 0) ? submit_at + 1 : RT + 1;
        for (int i = 1; i < ev; i++) begin
            tick();
            if (i == submit_at) submit = 1'b1;
        end
        check_eq({tag, "_pre_sound"}, 32'(play_sound), 32'd0);
        check_eq({tag, "_pre_round"}, 32'(round), 32'(exp_round - 1));
        tick();
        if (!sound_submit) submit = 1'b0;
        else               submit = 1'b1;
        check_eq({tag, "_sound"}, 32'(play_sound), 32'd1);
        check_eq({tag, "_val"}, 32'(val), 32'(exp_val));
        check_eq({tag, "_round"}, 32'(round), 32'(exp_round));
        check_eq({tag, "_correct"}, 32'(user_correct), 32'(exp_c));
        check_eq({tag, "_incorrect"}, 32'(user_incorrect), 32'(exp_i));
        tick();
        check_eq({tag, "_sound2"}, 32'(play_sound), 32'd1);
        tick();
        submit = 1'b0;
        check_eq({tag, "_sound_end"}, 32'(play_sound), 32'd0);
        check_eq({tag, "_round_hold"}, 32'(round), 32'(exp_round));
        check_eq({tag, "_cnt_hold"}, 32'(user_correct + user_incorrect), 32'(exp_c + exp_i));
        check_eq({tag, "_next_req"}, 32'(new_value), 32'(!last));
        check_eq({tag, "_done"}, 32'(game_done), 32'(last));
    endtask

    task automatic end_game(input string tag, input int exp_round);
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        ready = 1'b0;
        tick();
        check_eq({tag, "_idle"}, 32'(dbg_state), 32'd0);
        check_eq({tag, "_done_clr"}, 32'(game_done), 32'd0);
        check_eq({tag, "_round_kept"}, 32'(round), 32'(exp_round));
        tick();
    endtask

    initial begin
        #12;
        check_eq("rst_state", 32'(dbg_state), 32'd0);
        check_eq("rst_outs", {27'd0, new_value, play_sound, busy, game_done, val}, 32'd0);
        check_eq("rst_cnts", {26'd0, round, user_correct, user_incorrect}, 32'd0);
        reset = 1'b1;
        tick();
        tick();

        // Hex game, every round by timeout.
        game_mode = 2'b10; user_guess = 4'hA; rand_value = 4'hA; ready = 1'b1;
        tick();
        check_eq("start_latency_busy", 32'(busy), 32'd0);
        tick();
        check_eq("arm_busy", 32'(busy), 32'd1);
        check_eq("arm_new_value", 32'(new_value), 32'd1);
        play_round("hex1", 0, 1'b0, 1'b0, 1, 1, 0, 1'b0);
        play_round("hex2", 0, 1'b0, 1'b0, 2, 2, 0, 1'b0);
        play_round("hex3", 0, 1'b0, 1'b0, 3, 3, 0, 1'b1);
        end_game("hex", 3);

        // Octal game: early submit, coincident submit/timeout, ignored mode change.
        game_mode = 2'b11; user_guess = 4'hB; rand_value = 4'h3; ready = 1'b1;
        play_round("oct1", 2, 1'b0, 1'b0, 1, 1, 0, 1'b0);
        user_guess = 4'h5;
        play_round("oct2", RT, 1'b1, 1'b1, 2, 1, 1, 1'b0);
        user_guess = 4'hB; game_mode = 2'b10;
        play_round("oct3", 0, 1'b0, 1'b0, 3, 2, 1, 1'b1);
        end_game("oct", 3);

        // Dec game: >9 never matches, submit on first PLAY cycle.
        game_mode = 2'b01; user_guess = 4'hC; rand_value = 4'hC; ready = 1'b1;
        play_round("dec1", 0, 1'b0, 1'b1, 1, 0, 1, 1'b0);
        user_guess = 4'h9; rand_value = 4'h9;
        play_round("dec2", 1, 1'b0, 1'b0, 2, 1, 1, 1'b0);
        user_guess = 4'h7;
        play_round("dec3", 5, 1'b1, 1'b1, 3, 1, 2, 1'b1);
        end_game("dec", 3);

        // Abort on PLAY cycle 4 of round 2.
        game_mode = 2'b10; user_guess = 4'h1; rand_value = 4'h1; ready = 1'b1;
        play_round("ab1", 0, 1'b0, 1'b0, 1, 1, 0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        ready = 1'b0;
        tick();
        check_eq("abort_idle", 32'(dbg_state), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_sound", 32'(play_sound), 32'd0);
        tick();
        tick();
        check_eq("abort_round", 32'(round), 32'd1);
        check_eq("abort_correct", 32'(user_correct), 32'd1);
        ready = 1'b1;
        tick();
        tick();
        check_eq("restart_arm", 32'(new_value), 32'd1);
        check_eq("restart_cnts", {26'd0, round, user_correct, user_incorrect}, 32'd0);

        // Reset asserted mid-SOUND.
        for (int i = 0; i < 3; i++) tick();
        submit = 1'b1;
        tick();
        submit = 1'b0;
        check_eq("pre_rst_sound", 32'(play_sound), 32'd1);
        check_eq("pre_rst_round", 32'(round), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_sound", 32'(play_sound), 32'd0);
        check_eq("rst_mid_cnts", {26'd0, round, user_correct, user_incorrect}, 32'd0);
        check_eq("rst_mid_state", 32'(dbg_state), 32'd0);
        tick();
        reset = 1'b1;
        user_guess = 4'h6; rand_value = 4'h6;
        play_round("rr1", 0, 1'b0, 1'b0, 1, 1, 0, 1'b0);
        play_round("rr2", 4, 1'b0, 1'b0, 2, 2, 0, 1'b0);
        play_round("rr3", 0, 1'b0, 1'b0, 3, 3, 0, 1'b1);
        end_game("rr", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
